// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit frame state encoding and the fractional
// baud accumulator increment, reused by the receiver's oversampled generator.
package uart_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    BIT0  = 4'd2,
    BIT1  = 4'd3,
    BIT2  = 4'd4,
    BIT3  = 4'd5,
    BIT4  = 4'd6,
    BIT5  = 4'd7,
    BIT6  = 4'd8,
    BIT7  = 4'd9,
    STOP  = 4'd10
  } txState_t;

  // Rounded (baud * 2^oversample * 2^width) / clk_hz, pre-scaled by 16 to stay in range.
  function automatic logic [63:0] baud_inc(input logic [63:0] clk_hz,
                                           input logic [63:0] baud,
                                           input int          width,
                                           input int          oversample_log2);
    return ((baud << (width - 4 + oversample_log2)) + (clk_hz >> 5)) / (clk_hz >> 4);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Fractional-accumulator tick generator; the accumulator is held at zero while
// disabled so every enabled run starts from a clean phase.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 9600,
  parameter int AccWidth     = 16,
  parameter int Oversample   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [63:0]       IncFull = baud_inc(64'(ClkFrequency), 64'(Baud), AccWidth, Oversample);
  localparam logic [AccWidth:0] Inc     = IncFull[AccWidth:0];

  logic [AccWidth-1:0] acc;
  logic [AccWidth:0]   sum;

  // The carry is taken from the sum so the tick coincides with the edge that wraps acc.
  assign sum  = {1'b0, acc} + Inc;
  assign tick = enable & sum[AccWidth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (!enable) begin
      acc <= '0;
    end else begin
      acc <= sum[AccWidth-1:0];
    end
  end

endmodule

// File: rtl/transmit_data.sv
// 8N1 UART transmitter: accepts one byte per valid/ready handshake and shifts it
// out LSB first between a start bit and a stop bit.
module transmit_data
  import uart_pkg::*;
#(
  parameter int ClkFrequency          = 25000000,
  parameter int Baud                  = 9600,
  parameter int BaudGeneratorAccWidth = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  txState_t   state;
  logic [7:0] shiftReg;
  logic       baudTick;
  logic       baudEnable;

  assign baudEnable = (state != IDLE);

  baud_tick_gen #(
    .ClkFrequency(ClkFrequency),
    .Baud        (Baud),
    .AccWidth    (BaudGeneratorAccWidth),
    .Oversample  (0)
  ) baudGen (
    .clk   (clk),
    .reset (reset),
    .enable(baudEnable),
    .tick  (baudTick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shiftReg <= tx_data;
            state    <= START;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (baudTick) begin
            state <= BIT0;
            txd   <= shiftReg[0];
          end
        end
        // Data bits advance through consecutive encodings; txd takes the next LSB.
        BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6: begin
          if (baudTick) begin
            state    <= txState_t'(state + 4'd1);
            shiftReg <= shiftReg >> 1;
            txd      <= shiftReg[1];
          end
        end
        BIT7: begin
          if (baudTick) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
        STOP: begin
          if (baudTick) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
